soc_system_freq_divider: RTL



---
 rtl/soc_system_freq_divider_if.sv | 34 +++
 rtl/soc_system_freq_divider.sv | 104 ++++++++++
 2 files changed

// File: rtl/soc_system_freq_divider_if.sv
// Bundle between the divide-frequency PIO and the divider: divisor/control in, tick/square-wave out.
// FREQ_DIVIDER_TICK_COUNT_EN adds the 32-bit tick_count status signal.
interface soc_system_freq_divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] div_value;
  logic             sync_clear;
  logic             tick;
  logic             clk_out;
  logic             running;
`ifdef FREQ_DIVIDER_TICK_COUNT_EN
  logic [31:0]      tick_count;

  modport master (
    output div_value, sync_clear,
    input  tick, clk_out, running, tick_count
  );

  modport slave (
    input  div_value, sync_clear,
    output tick, clk_out, running, tick_count
  );
`else
  modport master (
    output div_value, sync_clear,
    input  tick, clk_out, running
  );

  modport slave (
    input  div_value, sync_clear,
    output tick, clk_out, running
  );
`endif
endinterface

// File: rtl/soc_system_freq_divider.sv
// Programmable clock-enable tick and 50%-duty divided square wave, retuned only at period boundaries.
// Optional macro FREQ_DIVIDER_TICK_COUNT_EN adds a free-running count of emitted ticks.
module soc_system_freq_divider #(
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  soc_system_freq_divider_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_p0,   state_p1;
  logic [WIDTH-1:0] shadow_p0,  shadow_p1;
  logic [WIDTH-1:0] cnt_p0,     cnt_p1;
  logic             tick_p0,    tick_p1;
  logic             clk_out_p0, clk_out_p1;
  logic [WIDTH-1:0] shadow_last;
  logic             div_zero;

  // The run state mirrors shadow != 0, so shadow_last is only consulted when it cannot underflow.
  assign shadow_last = shadow_p1 - {{(WIDTH-1){1'b0}}, 1'b1};
  assign div_zero    = (bus.div_value == '0);

  always_comb begin
    state_p0   = state_p1;
    shadow_p0  = shadow_p1;
    cnt_p0     = cnt_p1;
    tick_p0    = 1'b0;
    clk_out_p0 = clk_out_p1;

    if (div_zero) begin
      state_p0   = ST_STOP;
      shadow_p0  = '0;
      cnt_p0     = '0;
      clk_out_p0 = 1'b0;
    end else if (bus.sync_clear) begin
      state_p0   = ST_RUN;
      shadow_p0  = bus.div_value;
      cnt_p0     = '0;
      clk_out_p0 = 1'b0;
    end else if (state_p1 == ST_STOP) begin
      state_p0   = ST_RUN;
      shadow_p0  = bus.div_value;
      cnt_p0     = '0;
    end else if (cnt_p1 == shadow_last) begin
      cnt_p0     = '0;
      tick_p0    = 1'b1;
      clk_out_p0 = ~clk_out_p1;
      shadow_p0  = bus.div_value;
    end else begin
      cnt_p0     = cnt_p1 + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // ---- stage p0 -> p1: registered state and outputs ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p1   <= ST_STOP;
      shadow_p1  <= '0;
      cnt_p1     <= '0;
      tick_p1    <= 1'b0;
      clk_out_p1 <= 1'b0;
    end else begin
      state_p1   <= state_p0;
      shadow_p1  <= shadow_p0;
      cnt_p1     <= cnt_p0;
      tick_p1    <= tick_p0;
      clk_out_p1 <= clk_out_p0;
    end
  end

  assign bus.tick    = tick_p1;
  assign bus.clk_out = clk_out_p1;
  assign bus.running = (state_p1 == ST_RUN);

`ifdef FREQ_DIVIDER_TICK_COUNT_EN
  logic [31:0] tick_count_p0, tick_count_p1;

  // A stop holds the count; only a sync_clear that actually takes effect zeroes it.
  always_comb begin
    tick_count_p0 = tick_count_p1;
    if (!div_zero && bus.sync_clear) begin
      tick_count_p0 = '0;
    end else if (tick_p0) begin
      tick_count_p0 = tick_count_p1 + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_count_p1 <= '0;
    end else begin
      tick_count_p1 <= tick_count_p0;
    end
  end

  assign bus.tick_count = tick_count_p1;
`endif

endmodule
